// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-port stack arbiter.
package stack_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_CNT_W  = 4;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/stack_arbiter_lifo_core.sv
// LIFO storage plus occupancy counter; data_out holds popped data for one cycle, else 0.
module lifo_core
    import stack_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              push_pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] data_r;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic              wr_en_s;

    assign empty    = (count_r == {CNT_W{1'b0}});
    assign full     = (count_r == CNT_W'(DEPTH));
    assign wr_idx_s = count_r[IDX_W-1:0];
    assign rd_idx_s = wr_idx_s - IDX_W'(1);
    assign wr_en_s  = !reset && enable && (push_pop == OP_PUSH) && !full;
    assign data_out = data_r;

    // Storage array; contents survive reset and are unreachable while empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= data_in;
        end
    end

    // Occupancy counter and pop data register; both saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else if (enable && (push_pop == OP_PUSH)) begin
            data_r <= {DATA_W{1'b0}};
            if (!full) begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (enable && !empty) begin
            data_r  <= mem_r[rd_idx_s];
            count_r <= count_r - CNT_W'(1);
        end else begin
            data_r <= {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared LIFO.
// STACK_ARB_PRIORITY_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              busy
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              id_r;
    logic              op_r;
    logic [DATA_W-1:0] wdata_r;
    logic [1:0]        gnt_r;
    logic [1:0]        done_r;
    logic              err_r;
    logic              win_s;
    logic              latch_s;
    logic              exec_s;

`ifdef STACK_ARB_PRIORITY_EN
`else
    logic              ptr_r;

    // Last-grant pointer, refreshed whenever a command is latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= 1'b1;
        end else if (latch_s) begin
            ptr_r <= win_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Winner selection among the active requesters.
    always_comb begin
        win_s = 1'b0;
        if (req == 2'b11) begin
`ifdef STACK_ARB_PRIORITY_EN
            win_s = 1'b0;
`else
            win_s = ~ptr_r;
`endif
        end else if (req == 2'b10) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt_s = EXEC;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC:    state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    assign exec_s = (state_r == EXEC);

    // State, command latch and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            id_r    <= 1'b0;
            op_r    <= OP_POP;
            wdata_r <= {DATA_W{1'b0}};
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (latch_s) begin
                id_r    <= win_s;
                op_r    <= op[win_s];
                wdata_r <= win_s ? wdata1 : wdata0;
            end
            gnt_r  <= latch_s ? id_to_onehot(win_s) : 2'b00;
            done_r <= exec_s ? id_to_onehot(id_r) : 2'b00;
            err_r  <= exec_s ? ((op_r == OP_POP) ? stack_empty : stack_full) : 1'b0;
        end
    end

    lifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_lifo (
        .clk      (clk),
        .reset    (reset),
        .enable   (exec_s),
        .push_pop (op_r),
        .data_in  (wdata_r),
        .data_out (rdata),
        .empty    (stack_empty),
        .full     (stack_full)
    );

    // A pulse already on the wire is suppressed as soon as reset aborts the command.
    assign gnt  = gnt_r  & {2{~reset}};
    assign done = done_r & {2{~reset}};
    assign err  = err_r;
    assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomised and directed bench for stack_arbiter against a queue-based transaction model.
module tb_stack_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] op;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic [7:0] rdata;
    logic       stack_empty;
    logic       stack_full;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    stack_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .op          (op),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a queue is the stack, a phase counter tracks command progress.
    logic [7:0] stk[$];
    int         phase = 0;
    logic       ptr = 1'b1;
    logic       m_id;
    logic       m_op;
    logic [7:0] m_data;
    logic [1:0] exp_gnt = 2'b00;
    logic [1:0] exp_done = 2'b00;
    logic       exp_err = 1'b0;
    logic [7:0] exp_rdata = 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            phase = 0;
            stk.delete();
            ptr = 1'b1;
            exp_gnt = 2'b00; exp_done = 2'b00; exp_err = 1'b0; exp_rdata = 8'h00;
        end else begin
            exp_gnt = 2'b00; exp_done = 2'b00; exp_err = 1'b0; exp_rdata = 8'h00;
            if (phase == 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) begin
`ifdef STACK_ARB_PRIORITY_EN
                        m_id = 1'b0;
`else
                        m_id = (ptr == 1'b0) ? 1'b1 : 1'b0;
`endif
                    end else begin
                        m_id = req[1];
                    end
                    ptr    = m_id;
                    m_op   = op[m_id];
                    m_data = m_id ? wdata1 : wdata0;
                    exp_gnt = 2'b01 << m_id;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (m_op) begin
                    if (stk.size() < 8) stk.push_back(m_data);
                    else exp_err = 1'b1;
                end else begin
                    if (stk.size() > 0) exp_rdata = stk.pop_back();
                    else exp_err = 1'b1;
                end
                exp_done = 2'b01 << m_id;
                phase = 2;
            end else begin
                phase = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", gnt, exp_gnt);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("rdata", rdata, exp_rdata);
            chk("stack_empty", stack_empty, stk.size() == 0);
            chk("stack_full", stack_full, stk.size() == 8);
            chk("busy", busy, phase != 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issues one command from IDLE with fixed latency checks; returns the response.
    task automatic cmd(input int r, input logic o, input logic [7:0] d,
                       output logic e, output logic [7:0] rd);
        req[r] = 1'b1;
        op[r]  = o;
        if (r == 0) wdata0 = d; else wdata1 = d;
        tick();
        chk("cmd_gnt_latency", gnt, 2'b01 << r);
        req[r] = 1'b0;
        tick();
        chk("cmd_done_latency", done, 2'b01 << r);
        e  = err;
        rd = rdata;
        tick();
    endtask

    logic       e;
    logic [7:0] rd;
    logic [1:0] g[4];
    int         k;

    initial begin
        reset = 1'b1; req = 2'b00; op = 2'b00; wdata0 = 8'h00; wdata1 = 8'h00;
        do_reset();
        chk_en = 1'b1;
        chk("reset_empty", stack_empty, 1'b1);
        chk("reset_full", stack_full, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rdata", rdata, 8'h00);

        // First push
        cmd(0, 1'b1, 8'hA5, e, rd);
        chk("push_a5_err", e, 1'b0);
        chk("push_a5_not_empty", stack_empty, 1'b0);

        // LIFO order across requesters
        do_reset();
        cmd(0, 1'b1, 8'h11, e, rd);
        cmd(0, 1'b1, 8'h22, e, rd);
        cmd(0, 1'b1, 8'h33, e, rd);
        cmd(1, 1'b0, 8'h00, e, rd); chk("pop1", rd, 8'h33);
        cmd(1, 1'b0, 8'h00, e, rd); chk("pop2", rd, 8'h22);
        chk("pop2_not_empty", stack_empty, 1'b0);
        cmd(1, 1'b0, 8'h00, e, rd); chk("pop3", rd, 8'h11);
        chk("pop3_err", e, 1'b0);
        chk("pop3_empty", stack_empty, 1'b1);

        // Fill to saturation and overflow
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            cmd(i % 2, 1'b1, 8'(i), e, rd);
            if (i == 7) chk("full_after_7", stack_full, 1'b0);
            if (i == 8) chk("full_after_8", stack_full, 1'b1);
            if (i == 9) chk("push9_err", e, 1'b1);
        end
        chk("full_after_9", stack_full, 1'b1);
        cmd(0, 1'b0, 8'h00, e, rd);
        chk("pop_top_after_overflow", rd, 8'h08);

        // Underflow
        do_reset();
        cmd(1, 1'b0, 8'h00, e, rd);
        chk("underflow_err", e, 1'b1);
        chk("underflow_rdata", rd, 8'h00);

        // Tie arbitration with both requesters held
        do_reset();
        op = 2'b11; wdata0 = 8'hC0; wdata1 = 8'hC1; req = 2'b11;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            tick();
            if (gnt != 2'b00) begin
                g[k] = gnt;
                k++;
                if (k == 4) req = 2'b00;
            end
        end
        chk("tie_grant_count", k, 4);
`ifdef STACK_ARB_PRIORITY_EN
        chk("tie_g0", g[0], 2'b01); chk("tie_g1", g[1], 2'b01);
        chk("tie_g2", g[2], 2'b01); chk("tie_g3", g[3], 2'b01);
`else
        chk("tie_g0", g[0], 2'b01); chk("tie_g1", g[1], 2'b10);
        chk("tie_g2", g[2], 2'b01); chk("tie_g3", g[3], 2'b10);
`endif
        tick(); tick(); tick();

        // Reset during EXEC aborts the command
        do_reset();
        req[0] = 1'b1; op[0] = 1'b1; wdata0 = 8'h77;
        tick();
        reset = 1'b1; req = 2'b00;
        #1;
        chk("abort_gnt_masked", gnt, 2'b00);
        tick();
        chk("abort_done", done, 2'b00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_empty", stack_empty, 1'b1);
        reset = 1'b0;
        tick();
        chk("abort_done_after", done, 2'b00);
        chk("abort_empty_after", stack_empty, 1'b1);

        // Randomised traffic, occasional reset
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 249) == 0);
            for (int r = 0; r < 2; r++) begin
                if (!req[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[r] = 1'b1;
                        op[r]  = ($urandom_range(0, 99) < 55);
                        if (r == 0) wdata0 = 8'($urandom); else wdata1 = 8'($urandom);
                    end
                end else if (gnt[r]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[r] = 1'b0;
                    end else begin
                        op[r] = ($urandom_range(0, 99) < 55);
                        if (r == 0) wdata0 = 8'($urandom); else wdata1 = 8'($urandom);
                    end
                end
            end
            tick();
        end
        reset = 1'b0; req = 2'b00;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
